dma_priority_arbiter: RTL
=========================

DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 SHALL provide: one clock; reset is synchronous and active-high. Ports CLK and RESET.
REQ-002 SHALL have ports (name, direction, width, meaning):
- CLK, in, 1, system clock.
- RESET, in, 1, synchronous active-high reset.
- DREQ, in, 4, channel requests; active level set by dreqSenseLow.
- HLDA, in, 1, CPU hold acknowledge.
- transferDone, in, 1, one-cycle pulse from timing control at end of service.
- maskBits, in, 4, 1 = channel masked.
- controllerDisable, in, 1, command bit 2.
- rotatingPriority, in, 1, command bit 4.
- dreqSenseLow, in, 1, command bit 6.
- dackSenseHigh, in, 1, command bit 7.
- HRQ, out, 1, hold request to CPU.
- DACK, out, 4, channel acknowledges; active level set by dackSenseHigh.
- activeChannel, out, 2, index of the granted channel.
- channelValid, out, 1, high while a grant is held.
- requestStatus, out, 4, registered active requests, unmasked view, for status register bits 7:4.

Function
REQ-003 SHALL define the qualified request as req[i] = (DREQ[i] at its active level) & ~maskBits[i].
REQ-004 SHALL register requestStatus[i] = DREQ[i] at its active level every cycle, regardless of mask.
REQ-005 SHALL implement states IDLE, REQUEST, GRANT, RELEASE. HRQ = 1 in REQUEST and GRANT only.
REQ-006 IDLE -> REQUEST SHALL occur when |req & ~controllerDisable at an edge; HRQ is high from the next cycle.
REQ-007 In REQUEST, if req == 0 or controllerDisable = 1 at an edge, SHALL go to IDLE (HRQ low next cycle), regardless of HLDA.
REQ-008 In REQUEST, with HLDA = 1 and req != 0, SHALL latch the winner from req at that edge and go to GRANT. In the following cycle: DACK[winner] is active, activeChannel = winner, channelValid = 1.
REQ-009 In GRANT, the winner SHALL stay locked. Changes to DREQ, maskBits or controllerDisable do not preempt it.
REQ-010 In GRANT, on transferDone = 1, SHALL update the priority pointer and go to RELEASE. DACK goes inactive and channelValid = 0 next cycle.
REQ-011 In GRANT, if HLDA = 0 without transferDone, SHALL abort to IDLE: DACK inactive next cycle, pointer unchanged.
REQ-012 If transferDone and HLDA = 0 occur in the same cycle, SHALL treat it as completion (pointer updated), then go to IDLE directly.
REQ-013 RELEASE: HRQ = 0. SHALL wait for HLDA = 0, then go to IDLE. New requests are ignored until then.
REQ-014 Fixed priority: channel 0 highest, channel 3 lowest.
REQ-015 Rotating priority (rotatingPriority = 1): after channel n is served, channel n becomes lowest and (n+1) mod 4 highest (wrap 3 -> 0).
REQ-016 The pointer SHALL only change on completion, never on abort. It is retained when rotatingPriority toggles; fixed mode ignores it.
REQ-017 Inactive DACK level SHALL be ~dackSenseHigh on all four bits. Exactly one DACK bit is active, and only while channelValid = 1.
REQ-018 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-019 RESET SHALL force: state = IDLE, HRQ = 0, DACK all inactive, activeChannel = 0, channelValid = 0, requestStatus = 0, pointer = channel 0 highest.
REQ-020 RESET in any state, including mid-GRANT, SHALL take effect at the next edge and take priority over all other inputs.

Configuration
REQ-021 Macro DMA_ARB_ROTATE_EN:
- Defined: REQ-015/016 are implemented.
- Undefined: priority is always fixed, rotatingPriority is ignored, and no pointer register exists.

Structure
REQ-022 Shared package dma_pkg SHALL hold NUM_CHANNELS = 4, the channel index typedef (2-bit), and the arbiter state enum.
REQ-023 Winner selection SHALL be a combinational sub-module dma_priority_encoder: inputs req[3:0] and highest-priority index; outputs winner index and any-valid.

Verification
REQ-024 Fixed priority: DREQ = 4'b0110 active-high, mask = 0, HLDA raised 2 cycles after HRQ -> HRQ = 1, then DACK[1] active, activeChannel = 1.
REQ-025 Rotation (macro defined, rotatingPriority = 1): serve ch2 to transferDone, DREQ = 4'b1111 -> next grant ch3, then ch0 (wrap).
REQ-026 Cancel: DREQ[0] pulsed, dropped before HLDA -> HRQ deasserts next cycle, no DACK ever active.
REQ-027 Abort: HLDA dropped mid-GRANT on ch1 -> DACK inactive next cycle, pointer unchanged (next tie on 4'b1111 goes to the same highest channel as before).
REQ-028 Polarity: dreqSenseLow = 1, dackSenseHigh = 0, DREQ = 4'b1110 -> ch0 granted, DACK = 4'b1110.
REQ-029 RESET asserted during GRANT -> next cycle HRQ = 0, channelValid = 0, DACK all inactive, state IDLE.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types for the DMA priority arbiter: channel count, channel index, FSM states.
package dma_pkg;

  localparam int NUM_CHANNELS = 4;

  typedef logic [1:0] chan_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // One-hot acknowledge pattern at the requested polarity; all inactive when not valid.
  function automatic logic [NUM_CHANNELS-1:0] dack_vec(input logic valid, input chan_t ch,
                                                       input logic sense_high);
    logic [NUM_CHANNELS-1:0] onehot;
    onehot = valid ? (NUM_CHANNELS'(1) << ch) : '0;
    return sense_high ? onehot : ~onehot;
  endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational round-robin-capable priority encoder: first set request at or after
// i_highest (wrapping) wins.
module dma_priority_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CHANNELS-1:0] i_req,
  input  chan_t                   i_highest,
  output chan_t                   o_winner,
  output logic                    o_valid
);

  chan_t w_idx;

  // Scan from lowest to highest priority so the highest-priority hit is assigned last.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      w_idx = i_highest + chan_t'(k);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: hold-request handshake with the CPU, fixed or rotating priority.
// Rotating priority is built only when DMA_ARB_ROTATE_EN is defined.
//
// state      | meaning
// IDLE       | no request pending, HRQ low
// REQUEST    | HRQ high, waiting for HLDA
// GRANT      | winner locked, DACK active until transferDone or HLDA loss
// RELEASE    | service done, HRQ low, waiting for HLDA to drop
module dma_priority_arbiter
  import dma_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_CHANNELS-1:0] DREQ,
  input  logic                    HLDA,
  input  logic                    transferDone,
  input  logic [NUM_CHANNELS-1:0] maskBits,
  input  logic                    controllerDisable,
  input  logic                    rotatingPriority,
  input  logic                    dreqSenseLow,
  input  logic                    dackSenseHigh,
  output logic                    HRQ,
  output logic [NUM_CHANNELS-1:0] DACK,
  output chan_t                   activeChannel,
  output logic                    channelValid,
  output logic [NUM_CHANNELS-1:0] requestStatus
);

  arb_state_t              r_state;
  logic                    r_hrq;
  logic [NUM_CHANNELS-1:0] r_dack;
  chan_t                   r_ch;
  logic                    r_valid;
  logic [NUM_CHANNELS-1:0] r_status;

  logic [NUM_CHANNELS-1:0] w_dreq_act;
  logic [NUM_CHANNELS-1:0] w_req;
  chan_t                   w_highest;
  chan_t                   w_winner;
  logic                    w_any;

  assign w_dreq_act = dreqSenseLow ? ~DREQ : DREQ;
  assign w_req      = w_dreq_act & ~maskBits;

`ifdef DMA_ARB_ROTATE_EN
  chan_t r_ptr;
  assign w_highest = rotatingPriority ? r_ptr : chan_t'(0);
`else
  // Fixed priority only; the mode bit has no effect in this build.
  assign w_highest = {1'b0, rotatingPriority & 1'b0};
`endif

  dma_priority_encoder u_enc (
    .i_req     (w_req),
    .i_highest (w_highest),
    .o_winner  (w_winner),
    .o_valid   (w_any)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_hrq    <= 1'b0;
      r_dack   <= {NUM_CHANNELS{~dackSenseHigh}};
      r_ch     <= '0;
      r_valid  <= 1'b0;
      r_status <= '0;
`ifdef DMA_ARB_ROTATE_EN
      r_ptr    <= '0;
`endif
    end else begin
      r_status <= w_dreq_act;
      // Re-evaluated every cycle so a polarity change follows on the next edge.
      r_dack   <= dack_vec(r_valid, r_ch, dackSenseHigh);
      case (r_state)
        ST_IDLE: begin
          if (w_any && !controllerDisable) begin
            r_state <= ST_REQUEST;
            r_hrq   <= 1'b1;
          end
        end
        ST_REQUEST: begin
          if (!w_any || controllerDisable) begin
            r_state <= ST_IDLE;
            r_hrq   <= 1'b0;
          end else if (HLDA) begin
            r_state <= ST_GRANT;
            r_ch    <= w_winner;
            r_valid <= 1'b1;
            r_dack  <= dack_vec(1'b1, w_winner, dackSenseHigh);
          end
        end
        ST_GRANT: begin
          if (transferDone) begin
`ifdef DMA_ARB_ROTATE_EN
            r_ptr   <= r_ch + 2'd1;
`endif
            r_state <= HLDA ? ST_RELEASE : ST_IDLE;
            r_hrq   <= 1'b0;
            r_valid <= 1'b0;
            r_dack  <= {NUM_CHANNELS{~dackSenseHigh}};
          end else if (!HLDA) begin
            r_state <= ST_IDLE;
            r_hrq   <= 1'b0;
            r_valid <= 1'b0;
            r_dack  <= {NUM_CHANNELS{~dackSenseHigh}};
          end
        end
        ST_RELEASE: begin
          if (!HLDA) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign HRQ           = r_hrq;
  assign DACK          = r_dack;
  assign activeChannel = r_ch;
  assign channelValid  = r_valid;
  assign requestStatus = r_status;

endmodule
